// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage signal bundle: PC side, instruction memory and decode handshake.
interface if_fetch_unit_if #(
    parameter int unsigned ADDR_W  = if_pkg::ADDR_W,
    parameter int unsigned INSTR_W = if_pkg::INSTR_W
);
    logic [ADDR_W-1:0]  pc_addr;
    logic               flush;
    logic               pc_stall;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_rvalid;
    logic               if_valid;
    logic [ADDR_W-1:0]  if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               id_ready;

    modport master (
        input  pc_addr, flush, imem_rdata, imem_rvalid, id_ready,
        output pc_stall, imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output pc_addr, flush, imem_rdata, imem_rvalid, id_ready,
        input  pc_stall, imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/if_fetch_fifo.sv
// Synchronous fetch queue with occupancy count and a synchronous clear.
module if_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: issues one imem read per cycle while queue credit remains and
// buffers {pc, instr} for decode; flush drops queued and in-flight fetches.
module if_fetch_unit #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = if_pkg::ADDR_W,
    parameter int unsigned INSTR_W = if_pkg::INSTR_W
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);
    import if_pkg::*;

    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W:0]     used;
    logic               req;
    logic               push;
    logic               pop;
    logic               inflight;
    logic               discard;
    logic [ADDR_W-1:0]  inflight_pc;

    // Credit counts the outstanding read so a response always has a free slot.
    assign used = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign req  = rst & ~bus.flush & (used < (CNT_W + 1)'(DEPTH));
    assign push = bus.imem_rvalid & inflight & ~discard & ~bus.flush;
    assign pop  = bus.if_valid & bus.id_ready & ~bus.flush;

    assign bus.imem_req  = req;
    assign bus.imem_addr = bus.pc_addr;
    assign bus.pc_stall  = ~req & ~(bus.flush & rst);
    assign bus.if_valid  = (count != '0);
    assign bus.if_pc     = bus.if_valid ? head[ENTRY_W-1 -: ADDR_W] : '0;
    assign bus.if_instr  = bus.if_valid ? head[INSTR_W-1:0] : INSTR_W'(INSTR_NOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
            discard     <= 1'b0;
        end else begin
            inflight <= req;
            if (req) begin
                inflight_pc <= bus.pc_addr;
                discard     <= 1'b0;
            end else if (bus.flush && inflight) begin
                discard <= 1'b1;
            end
        end
    end

    if_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({inflight_pc, bus.imem_rdata}),
        .pop       (pop),
        .clear     (bus.flush),
        .count     (count),
        .head      (head)
    );

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of pc_adder. Each cycle it takes the current PC address and issues an instruction-memory read with a fixed 1-cycle latency. It buffers the returned {pc, instr} pairs in a small FIFO and presents them to decode with a valid/ready handshake. It drives pc_stall back to the PC logic when the buffer has no credit, and on flush it discards queued and in-flight fetches.

Parameters:
DEPTH, 4, fetch-queue entries (legal range 2..8; full throughput needs at least 2).
ADDR_W, 64, PC / address width.
INSTR_W, 32, instruction width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
pc_addr  in  ADDR_W  current PC from pc_adder.
flush  in  1  redirect pulse; PC loads the branch target this cycle.
imem_req  out  1  read request to instruction memory.
imem_addr  out  ADDR_W  read address; always equals pc_addr.
imem_rdata  in  INSTR_W  read data, valid when imem_rvalid is high.
imem_rvalid  in  1  response strobe, exactly 1 cycle after an accepted imem_req.
if_valid  out  1  head entry is valid for decode.
if_pc  out  ADDR_W  PC of the head entry.
if_instr  out  INSTR_W  instruction of the head entry.
id_ready  in  1  decode accepts the head entry this cycle.
pc_stall  out  1  PC must hold its value this cycle.

Behaviour:
- State:
  - FIFO storage with count register (0..DEPTH).
  - inflight bit and inflight_pc register.
  - discard bit.
- Reset (rst=0, asynchronous): count=0, inflight=0, discard=0, head/tail pointers=0.
  - Outputs while in reset: if_valid=0, if_pc=0, if_instr=0, imem_req=0, pc_stall=1.
- Issue rule (combinational): imem_req = rst & ~flush & ((count + inflight) < DEPTH).
  - There is no combinational path from id_ready to imem_req.
- pc_stall = ~imem_req & ~flush. The PC is free to load the branch target in a flush cycle.
- Accepted request (imem_req=1 at edge): inflight<=1, inflight_pc<=pc_addr, discard<=0.
- No request at edge: inflight<=0.
- Response (imem_rvalid=1):
  - Pushed as {inflight_pc, imem_rdata} only if inflight=1, discard=0 and flush=0.
  - Otherwise it is dropped silently; an rvalid with inflight=0 is a protocol error and is ignored.
- Pop: if_valid & id_ready advances the head. Push and pop in the same cycle leave count unchanged.
- Credit guarantees a push never finds the FIFO full; an overflow would indicate a bug.
  - The bench asserts count<=DEPTH.
- Flush (flush=1 at edge):
  - count<=0 and pointers reset.
  - If inflight=1, discard<=1 so the next cycle's response is dropped.
  - A pop in the same cycle is ignored; flush wins.
  - A response arriving in the flush cycle is dropped.
- Outputs:
  - if_valid = (count != 0).
  - if_pc/if_instr = head entry when count != 0; otherwise 0 and INSTR_NOP (32'h0).
- Latency: pc_addr sampled at edge N appears on if_* at cycle N+2 when the queue was empty.
  - Sustained throughput is 1 instruction per cycle while id_ready=1.
- Backpressure: with id_ready=0, the queue fills to DEPTH.
  - imem_req deasserts once count+inflight=DEPTH; pc_stall=1.
  - Issue resumes the first cycle after a pop reduces count.
- Reset mid-operation: all state clears immediately. A response arriving after reset release is dropped because inflight=0.

Decomposition:
- Package if_pkg:
  - ADDR_W, INSTR_W defaults.
  - INSTR_NOP = 32'h0.
  - A fetch-entry packed type {pc, instr}.
- One sub-module: if_fetch_fifo.
  - Synchronous FIFO, DEPTH entries, parameterised width.
  - Ports: push, pop, clear, count, head.
  - Pointer wrap at DEPTH-1→0.
- if_fetch_unit holds the issue/credit/discard logic.

Test Plan:
1. Reset, then pc_addr=0x0,0x4,0x8,… with memory returning instr=0x20000000+pc and id_ready=1.
   - if_valid rises 2 cycles after the first request.
   - if_pc sequence 0x0,0x4,0x8 back-to-back with no bubbles; pc_stall=0 throughout.
2. Same stream with id_ready=0 from cycle 3.
   - count reaches 4, imem_req=0, pc_stall=1, if_pc stays 0x0.
   - Raise id_ready: entries drain 0x0..0xC in order, and issue resumes the next cycle.
3. flush while count=2 and inflight=1 (pc 0x10 outstanding).
   - The next cycle has if_valid=0, and the 0x10 response is dropped.
   - pc_addr=0x100 after flush appears on if_pc 2 cycles later.
4. flush in the same cycle as imem_rvalid and id_ready=1.
   - Nothing is pushed, the pop is ignored, and count=0 next cycle.
5. Assert rst=0 asynchronously mid-stream, between edges, with count=3.
   - if_valid=0 immediately; pc_stall=1.
   - The response arriving in the cycle after release is dropped.
6. Spurious imem_rvalid=1 with no prior request: if_valid stays 0 and count stays 0.
